// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin front end for a single i2c_controller.
// Latches the winning command onto the controller inputs, follows the
// controller's ready bit through launch, run and idle qualification, and
// recovers a hung controller with a pulsed active-low reset.
module i2c_txn_arbiter #(
  parameter int IDLE_QUAL = 256,
  parameter int START_TO  = 1024,
  parameter int XFER_TO   = 65535,
  parameter int RST_HOLD  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_rw,
  input  logic [13:0] i_dev_addr,
  input  logic [15:0] i_reg_addr,
  input  logic [15:0] i_w_data,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err,
  output logic [7:0]  o_rd_data,
  output logic [6:0]  o_i2c_dev_addr,
  output logic [7:0]  o_i2c_reg_addr,
  output logic [7:0]  o_i2c_w_data,
  output logic [31:0] o_i2c_ctrl,
  output logic        o_i2c_rst_n,
  input  logic [31:0] i_i2c_status,
  input  logic [7:0]  i_i2c_rd_data
);

  localparam int TMAX = (XFER_TO > START_TO) ? XFER_TO : START_TO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int QW   = $clog2(IDLE_QUAL + 1);
  localparam int HW   = $clog2(RST_HOLD + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_QUAL    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          win_q, win_d;
  logic          last_q, last_d;       // index granted most recently
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdat_q, wdat_d;
  logic          en_q, en_d;
  logic          rw_q, rw_d;
  logic          rst_n_q, rst_n_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [QW-1:0] qual_q, qual_d;
  logic          sync1_q, sync2_q;
  logic          rst_n_cd;
  logic [HW-1:0] hold_cd;
  logic          win_sel;
  logic          ready;
  logic          unused_status;

  assign ready         = sync2_q;
  assign unused_status = ^i_i2c_status[31:1];

  // Count down an active controller-reset pulse; releases after RST_HOLD cycles.
  always_comb begin
    rst_n_cd = rst_n_q;
    hold_cd  = hold_q;
    if (!rst_n_q) begin
      if (hold_q == '0) rst_n_cd = 1'b1;
      else              hold_cd  = hold_q - HW'(1);
    end
  end

  // Arbitration and transaction-tracking state machine.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    last_d    = last_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rd_data_d = rd_data_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdat_d    = wdat_q;
    en_d      = en_q;
    rw_d      = rw_q;
    rst_n_d   = rst_n_cd;
    hold_d    = hold_cd;
    timer_d   = timer_q;
    qual_d    = qual_q;
    win_sel   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Hold off new work while a controller reset pulse is still active.
        if (rst_n_q && (i_req != 2'b00)) begin
          win_sel   = (i_req == 2'b11) ? ~last_q : i_req[1];
          win_d     = win_sel;
          gnt_d     = win_sel ? 2'b10 : 2'b01;
          dev_d     = win_sel ? i_dev_addr[13:7] : i_dev_addr[6:0];
          reg_d     = win_sel ? i_reg_addr[15:8] : i_reg_addr[7:0];
          wdat_d    = win_sel ? i_w_data[15:8]   : i_w_data[7:0];
          rw_d      = i_rw[win_sel];
          en_d      = 1'b1;
          timer_d   = '0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!ready) begin
          en_d    = 1'b0;
          timer_d = '0;
          state_d = S_RUN;
        end else if (timer_q == TW'(START_TO - 1)) begin
          state_d = S_RECOVER;
          en_d    = 1'b0;
          rst_n_d = 1'b0;
          hold_d  = HW'(RST_HOLD - 1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RUN, S_QUAL: begin
        // The transfer timer spans RUN and QUAL; a ready blip does not restart it.
        if (timer_q == TW'(XFER_TO - 1)) begin
          state_d = S_RECOVER;
          en_d    = 1'b0;
          rst_n_d = 1'b0;
          hold_d  = HW'(RST_HOLD - 1);
        end else begin
          timer_d = timer_q + TW'(1);
          if (state_q == S_RUN) begin
            if (ready) begin
              qual_d  = '0;
              state_d = S_QUAL;
            end
          end else if (!ready) begin
            state_d = S_RUN;
          end else if (qual_q == QW'(IDLE_QUAL - 1)) begin
            done_d  = gnt_q;
            if (rw_q) rd_data_d = i_i2c_rd_data;
            state_d = S_DONE;
          end else begin
            qual_d = qual_q + QW'(1);
          end
        end
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        last_d  = win_q;
        state_d = S_IDLE;
      end
      S_RECOVER: begin
        if (hold_q == '0) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; a reset that interrupts a transaction also resets the controller.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rd_data_q <= 8'h00;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdat_q    <= 8'h00;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      timer_q   <= '0;
      qual_q    <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      if (state_q != S_IDLE) begin
        rst_n_q <= 1'b0;
        hold_q  <= HW'(RST_HOLD - 1);
      end else begin
        rst_n_q <= rst_n_cd;
        hold_q  <= hold_cd;
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      last_q    <= last_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdat_q    <= wdat_d;
      en_q      <= en_d;
      rw_q      <= rw_d;
      timer_q   <= timer_d;
      qual_q    <= qual_d;
      sync1_q   <= i_i2c_status[0];
      sync2_q   <= sync1_q;
      rst_n_q   <= rst_n_d;
      hold_q    <= hold_d;
    end
  end

  assign o_gnt          = gnt_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_rd_data      = rd_data_q;
  assign o_i2c_dev_addr = dev_q;
  assign o_i2c_reg_addr = reg_q;
  assign o_i2c_w_data   = wdat_q;
  assign o_i2c_ctrl     = {28'h0000000, 2'b00, rw_q, en_q};
  assign o_i2c_rst_n    = rst_n_q;

endmodule
